// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
// Instruction-memory fetch stage between the control unit and instruction memory.
// It latches the fetch address into the MAR and runs a req/ack read against a
// variable-latency memory. The returned word is buffered and loaded into the
// instruction register that drives the decoder. A read that is never acknowledged
// ends in a sticky fault, and the HLT encoding is substituted for the word.
//
// Ports:
//   clk               in   clock, rising edge
//   reset_cycle       in   asynchronous active-high reset
//   pc_addr           in   fetch address from the PC
//   signal_I_MAR      in   load pc_addr into the MAR
//   signal_read_I_mem in   level; its rising edge starts one read
//   signal_IR         in   load the fetched word into the IR
//   imem_req          out  read request, held until ack
//   imem_addr         out  read address (MAR contents)
//   imem_rdata        in   read data, valid with imem_ack
//   imem_ack          in   one-cycle data-valid pulse
//   instruction       out  IR contents
//   fetch_stall       out  read outstanding, control unit must hold
//   fetch_fault       out  sticky timeout flag
module imem_fetch_ctrl #(
  parameter int                 ADDR_W     = 8,
  parameter int                 INSTR_W    = 16,
  parameter int                 TIMEOUT    = 15,
  parameter logic [INSTR_W-1:0] FAULT_WORD = 16'hF800
) (
  input  logic               clk,
  input  logic               reset_cycle,
  input  logic [ADDR_W-1:0]  pc_addr,
  input  logic               signal_I_MAR,
  input  logic               signal_read_I_mem,
  input  logic               signal_IR,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic [INSTR_W-1:0] instruction,
  output logic               fetch_stall,
  output logic               fetch_fault
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID, S_FAULT} state_t;

  localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

  state_t               r_state;
  logic [ADDR_W-1:0]    r_mar;
  logic [INSTR_W-1:0]   r_buf;
  logic [INSTR_W-1:0]   r_instr;
  logic [7:0]           r_wait_cnt;
  logic                 r_ir_pend;
  logic                 r_rd_q;

  state_t               w_state_next;
  logic [7:0]           w_cnt_next;
  logic                 w_pend_next;
  logic                 w_buf_load;
  logic [INSTR_W-1:0]   w_buf_d;
  logic                 w_ir_load;
  logic [INSTR_W-1:0]   w_ir_d;
  logic                 w_rd_rise;
  logic [8:0]           w_cnt_inc;

  assign w_rd_rise = signal_read_I_mem & ~r_rd_q;
  assign w_cnt_inc = {1'b0, r_wait_cnt} + 9'd1;

  // The request address is the MAR. A same-cycle MAR load and read start
  // loads the MAR on the very edge that enters REQ, so the request already
  // carries the new (jump) address without a separate bypass path.
  assign imem_addr   = r_mar;
  assign imem_req    = (r_state == S_REQ);
  assign fetch_fault = (r_state == S_FAULT);
  assign fetch_stall = (r_state == S_REQ) | w_rd_rise;
  assign instruction = r_instr;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_wait_cnt;
    w_pend_next  = r_ir_pend;
    w_buf_load   = 1'b0;
    w_buf_d      = imem_rdata;
    w_ir_load    = 1'b0;
    w_ir_d       = r_buf;
    case (r_state)
      S_IDLE: begin
        if (w_rd_rise) begin
          w_state_next = S_REQ;
          w_cnt_next   = 8'd0;
          w_pend_next  = 1'b0;
        end
      end
      S_VALID: begin
        if (signal_IR) begin
          w_ir_load = 1'b1;
          w_ir_d    = r_buf;
        end
        if (w_rd_rise) begin
          w_state_next = S_REQ;
          w_cnt_next   = 8'd0;
          w_pend_next  = 1'b0;
        end
      end
      S_REQ: begin
        // An IR request made during the wait (or on the ack cycle itself)
        // takes the memory word directly instead of waiting for VALID.
        if (imem_ack) begin
          w_state_next = S_VALID;
          w_buf_load   = 1'b1;
          w_buf_d      = imem_rdata;
          w_pend_next  = 1'b0;
          if (r_ir_pend | signal_IR) begin
            w_ir_load = 1'b1;
            w_ir_d    = imem_rdata;
          end
        end else if (w_cnt_inc == TIMEOUT_W) begin
          w_state_next = S_FAULT;
          w_buf_load   = 1'b1;
          w_buf_d      = FAULT_WORD;
          w_pend_next  = 1'b0;
          w_cnt_next   = w_cnt_inc[7:0];
          if (r_ir_pend | signal_IR) begin
            w_ir_load = 1'b1;
            w_ir_d    = FAULT_WORD;
          end
        end else begin
          w_cnt_next = w_cnt_inc[7:0];
          if (signal_IR) w_pend_next = 1'b1;
        end
      end
      S_FAULT: begin
        // Terminal until reset; read starts and late acks are ignored.
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      r_state    <= S_IDLE;
      r_mar      <= '0;
      r_buf      <= '0;
      r_instr    <= '0;
      r_wait_cnt <= '0;
      r_ir_pend  <= 1'b0;
      r_rd_q     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_cnt_next;
      r_ir_pend  <= w_pend_next;
      r_rd_q     <= signal_read_I_mem;
      if (signal_I_MAR) r_mar   <= pc_addr;
      if (w_buf_load)   r_buf   <= w_buf_d;
      if (w_ir_load)    r_instr <= w_ir_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_cycle;
  logic [7:0]  pc_addr;
  logic        signal_I_MAR;
  logic        signal_read_I_mem;
  logic        signal_IR;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic [15:0] instruction;
  logic        fetch_stall;
  logic        fetch_fault;

  imem_fetch_ctrl #(
    .ADDR_W(8), .INSTR_W(16), .TIMEOUT(4), .FAULT_WORD(16'hF800)
  ) dut (
    .clk(clk), .reset_cycle(reset_cycle), .pc_addr(pc_addr),
    .signal_I_MAR(signal_I_MAR), .signal_read_I_mem(signal_read_I_mem),
    .signal_IR(signal_IR), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .instruction(instruction),
    .fetch_stall(fetch_stall), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    int          nwait;
    bit          ir_req;
    bit          bypass;
  } vec_t;

  vec_t        vecs[5];
  logic [15:0] sb_q[$];
  logic [15:0] exp_w;
  int          total = 0;
  int          bad = 0;
  int          stall_cnt;
  int          req_cnt;
  logic [7:0]  last_req_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample outputs on the falling edge, return 1ns after the rising edge.
  task automatic step();
    @(negedge clk);
    if (fetch_stall) stall_cnt++;
    if (imem_req) begin
      req_cnt++;
      last_req_addr = imem_addr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input vec_t v);
    stall_cnt = 0;
    req_cnt = 0;
    last_req_addr = 8'h00;
    pc_addr = v.addr;
    signal_I_MAR = 1'b1;
    if (!v.bypass) begin
      step();
      signal_I_MAR = 1'b0;
      pc_addr = ~v.addr;
    end
    signal_read_I_mem = 1'b1;
    sb_q.push_back(v.data);
    step();
    signal_read_I_mem = 1'b0;
    signal_I_MAR = 1'b0;
    pc_addr = ~v.addr;
    for (int i = 0; i < v.nwait; i++) begin
      signal_IR = (v.ir_req && i == 0);
      imem_rdata = 16'(i * 16'h0101);
      step();
      signal_IR = 1'b0;
    end
    imem_ack = 1'b1;
    imem_rdata = v.data;
    signal_IR = (v.ir_req && v.nwait == 0);
    step();
    imem_ack = 1'b0;
    signal_IR = 1'b0;
    imem_rdata = 16'hDEAD;
    if (!v.ir_req) begin
      signal_IR = 1'b1;
      step();
      signal_IR = 1'b0;
    end
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{addr: 8'h05, data: 16'h1234, nwait: 0, ir_req: 1'b0, bypass: 1'b0};
    vecs[1] = '{addr: 8'h10, data: 16'hABCD, nwait: 2, ir_req: 1'b1, bypass: 1'b0};
    vecs[2] = '{addr: 8'hA0, data: 16'h5A5A, nwait: 1, ir_req: 1'b0, bypass: 1'b1};
    vecs[3] = '{addr: 8'hFF, data: 16'hFFFF, nwait: 0, ir_req: 1'b1, bypass: 1'b0};
    vecs[4] = '{addr: 8'h00, data: 16'h0001, nwait: 3, ir_req: 1'b0, bypass: 1'b0};

    reset_cycle = 1'b1;
    pc_addr = 8'h00;
    signal_I_MAR = 1'b0;
    signal_read_I_mem = 1'b0;
    signal_IR = 1'b0;
    imem_rdata = 16'h0000;
    imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_cycle = 1'b0;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_instr", instruction, 0);
    check("rst_stall", fetch_stall, 0);
    check("rst_fault", fetch_fault, 0);

    // Table-driven fetches through the scoreboard.
    for (int k = 0; k < 5; k++) begin
      do_fetch(vecs[k]);
      exp_w = sb_q.pop_front();
      check($sformatf("v%0d_instr", k), instruction, exp_w);
      check($sformatf("v%0d_addr", k), imem_addr, vecs[k].addr);
      check($sformatf("v%0d_req_addr", k), last_req_addr, vecs[k].addr);
      check($sformatf("v%0d_stall", k), stall_cnt, vecs[k].nwait + 2);
      check($sformatf("v%0d_reqcyc", k), req_cnt, vecs[k].nwait + 1);
      check($sformatf("v%0d_fault", k), fetch_fault, 0);
    end

    // Level-held read: one request only.
    stall_cnt = 0;
    req_cnt = 0;
    signal_read_I_mem = 1'b1;
    step();
    imem_ack = 1'b1;
    imem_rdata = 16'h7777;
    step();
    imem_ack = 1'b0;
    repeat (3) step();
    signal_read_I_mem = 1'b0;
    step();
    check("lvl_reqcyc", req_cnt, 1);
    check("lvl_stall", stall_cnt, 2);
    check("lvl_instr_hold", instruction, 16'h0001);
    signal_IR = 1'b1;
    step();
    signal_IR = 1'b0;
    check("lvl_instr", instruction, 16'h7777);

    // Back-to-back: IR keeps the old word until the new ack and IR load.
    signal_read_I_mem = 1'b1;
    step();
    signal_read_I_mem = 1'b0;
    check("b2b_req", imem_req, 1);
    step();
    check("b2b_hold1", instruction, 16'h7777);
    imem_ack = 1'b1;
    imem_rdata = 16'h4242;
    step();
    imem_ack = 1'b0;
    check("b2b_hold2", instruction, 16'h7777);
    signal_IR = 1'b1;
    step();
    signal_IR = 1'b0;
    check("b2b_instr", instruction, 16'h4242);

    // Reset in the middle of a read, followed by a stale ack.
    signal_read_I_mem = 1'b1;
    step();
    signal_read_I_mem = 1'b0;
    check("mid_req", imem_req, 1);
    reset_cycle = 1'b1;
    #1;
    check("mid_rst_req", imem_req, 0);
    check("mid_rst_instr", instruction, 0);
    check("mid_rst_addr", imem_addr, 0);
    #2;
    reset_cycle = 1'b0;
    @(posedge clk);
    #1;
    imem_ack = 1'b1;
    imem_rdata = 16'hBEEF;
    step();
    imem_ack = 1'b0;
    check("stale_req", imem_req, 0);
    check("stale_instr", instruction, 0);
    signal_IR = 1'b1;
    step();
    signal_IR = 1'b0;
    check("idle_ir_instr", instruction, 0);

    // Timeout with a pending IR load.
    pc_addr = 8'h33;
    signal_I_MAR = 1'b1;
    step();
    signal_I_MAR = 1'b0;
    stall_cnt = 0;
    req_cnt = 0;
    signal_read_I_mem = 1'b1;
    sb_q.push_back(16'hF800);
    step();
    signal_read_I_mem = 1'b0;
    signal_IR = 1'b1;
    step();
    signal_IR = 1'b0;
    for (int i = 0; i < 20 && !fetch_fault; i++) step();
    exp_w = sb_q.pop_front();
    check("to_fault", fetch_fault, 1);
    check("to_reqcyc", req_cnt, 4);
    check("to_req", imem_req, 0);
    check("to_instr", instruction, exp_w);
    imem_ack = 1'b1;
    imem_rdata = 16'h1111;
    signal_read_I_mem = 1'b1;
    step();
    imem_ack = 1'b0;
    signal_read_I_mem = 1'b0;
    step();
    signal_read_I_mem = 1'b1;
    step();
    signal_read_I_mem = 1'b0;
    step();
    check("to_late_req", imem_req, 0);
    check("to_late_fault", fetch_fault, 1);
    check("to_late_instr", instruction, 16'hF800);

    reset_cycle = 1'b1;
    #1;
    check("to_rst_fault", fetch_fault, 0);
    check("to_rst_instr", instruction, 0);
    #2;
    reset_cycle = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
